prog_mem_loader: RTL and testbench
==================================

# prog_mem_loader

Boot-time writer for the instruction program memory. It receives a length-prefixed, checksummed byte stream over a valid/ready handshake and packs it into 32-bit words. It writes those words into consecutive program-memory addresses. It holds the processor core in reset until the image is complete and verified. It sits between the host/serial link and the write port of the program memory that the fetch stage reads.

## Interface
Parameters:
- BASE_ADDR, 16'h0000, program-memory address of the first loaded word.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle pulse that begins a load
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte; transfer occurs when rx_valid & rx_ready at a rising edge
- pm_we  out  1  program-memory write strobe, one cycle per word
- pm_addr  out  16  write address
- pm_wdata  out  32  write data
- cpu_reset_n  out  1  active-low core reset; 0 except in DONE
- busy  out  1  load in progress
- done  out  1  image loaded and checksum matched
- error  out  1  checksum mismatch
- words_loaded  out  16  count of words written in current load

## Operation
- Stream format:
  - 2-byte word count N, MSB first.
  - N words of 4 bytes each, MSB first.
  - 4-byte trailer, MSB first, equal to the XOR of all N data words. N=0 gives an expected trailer of 0.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
- State transitions:
  - IDLE/DONE/ERROR --start--> LEN_HI. Taking this transition clears done, error, words_loaded and the checksum accumulator, and drives cpu_reset_n to 0.
  - LEN_HI --byte--> LEN_LO.
  - LEN_LO --byte--> DATA if N≠0, else CHECK.
  - DATA: after the 4th byte of a word, issue a write. The word index increments. After word N go to CHECK.
  - CHECK: after 4 trailer bytes, go to DONE if the trailer equals the accumulator, else ERROR.
- rx_ready = 1 in LEN_HI, LEN_LO, DATA and CHECK, and 0 otherwise. Bytes offered in IDLE/DONE/ERROR are not consumed.
- start is ignored while busy.
- pm_addr = (BASE_ADDR + index) mod 2^16; wraps FFFF→0000.
- N up to 65535.
- busy = 1 in LEN_HI..CHECK.
- cpu_reset_n = 1 only in DONE.

## Timing
- Reset values: rx_ready 0, pm_we 0, pm_addr 0, pm_wdata 0, cpu_reset_n 0, busy 0, done 0, error 0, words_loaded 0, state IDLE.
- Write latency:
  - pm_we, pm_addr and pm_wdata are registered.
  - They are valid for exactly the one cycle following the edge that accepts a word's 4th byte.
  - words_loaded increments on that same edge.
- No backpressure from writes: rx_ready stays 1 during the write cycle. Back-to-back bytes at one per cycle are sustained.
- rx_valid may drop between any bytes. Partial-word state is held indefinitely.
- The start edge that leaves IDLE makes busy=1 and rx_ready=1 in the following cycle.
- On the edge accepting the last trailer byte, the next cycle shows:
  - on a match: done=1, cpu_reset_n=1, busy=0;
  - on a mismatch: error=1, cpu_reset_n=0.
- start coinciding with a byte handshake in DONE/ERROR: rx_ready is 0 there, so no byte is consumed.
- Reset mid-load:
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - Memory holds a partial image. The core stays in reset until a fresh, complete load finishes.

## Structure
- Shared package holds:
  - the state enum;
  - constants LEN_BYTES=2, WORD_BYTES=4, CSUM_BYTES=4;
  - the default BASE_ADDR.
- Sub-module `byte_to_word_packer`:
  - an 8→32 shift register with a 2-bit byte counter;
  - emits word_valid with the assembled word;
  - is reused for the length, data and trailer fields, with clear on start/reset.
- The top level holds the FSM, address/word counters and the XOR accumulator.

## Test plan
- Normal load:
  - Stimulus: start; bytes 00 02, DE AD BE EF, 12 34 56 78, CC 99 E8 97.
  - Required: pm_we at addr 0000 with DEADBEEF, then at 0001 with 12345678; done=1, cpu_reset_n=1, words_loaded=2, error=0.
- Bad checksum:
  - Stimulus: same stream with trailer 00 00 00 00.
  - Required: error=1, done=0, cpu_reset_n stays 0; a following start plus the correct stream gives done=1.
- Zero length:
  - Stimulus: 00 00, 00 00 00 00.
  - Required: done=1, no pm_we pulse, words_loaded=0.
- Handshake gaps:
  - Stimulus: random rx_valid idle cycles inside the normal-load stream, plus bytes offered while IDLE.
  - Required: identical writes and result; the IDLE bytes are not consumed (rx_ready=0).
- Reset mid-word:
  - Stimulus: assert reset after byte 2 of word 0.
  - Required: all outputs at reset values without a clock edge; a subsequent full load writes addr 0000 correctly.
- Wrap-around:
  - Stimulus: BASE_ADDR=16'hFFFF, normal-load stream.
  - Required: writes at FFFF then 0000, done=1.

Source files
------------

// File: rtl/prog_mem_loader_pkg.sv
// Shared types and constants for the boot-time program-memory loader.
package prog_mem_loader_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CSUM_BYTES = 4;

  localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  // States in which the loader owns the stream.
  function automatic logic is_busy(state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles MSB-first bytes into a field of up to four bytes; field length is
// selected per byte by last_idx so one packer serves length, data and trailer.
module byte_to_word_packer
  import prog_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic [CNT_W-1:0]  last_idx,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  logic [WORD_W-BYTE_W-1:0] shift_q;
  logic [CNT_W-1:0]         cnt_q;

  // Completed field is visible combinationally alongside its final byte.
  assign word_c       = {shift_q, byte_data};
  assign word_valid_c = byte_valid && (cnt_q == last_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= word_c[WORD_W-BYTE_W-1:0];
      cnt_q   <= word_valid_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/prog_mem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream, writes
// words to program memory and releases the core only after a verified image.
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [WORD_W-1:0] pm_wdata,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);

  state_e              state_q, next_state;
  logic [ADDR_W-1:0]   len_q, idx_q;
  logic [WORD_W-1:0]   acc_q;

  logic                accept_c, start_c, write_c, len_load_c;
  logic [CNT_W-1:0]    last_idx_c;
  logic                word_valid_c;
  logic [WORD_W-1:0]   word_c;

  byte_to_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (start_c),
    .byte_valid   (accept_c),
    .byte_data    (rx_data),
    .last_idx     (last_idx_c),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  assign words_loaded = idx_q;

  always_comb begin
    next_state = state_q;
    accept_c   = rx_valid && rx_ready;
    start_c    = 1'b0;
    write_c    = 1'b0;
    len_load_c = 1'b0;
    last_idx_c = CNT_W'(WORD_BYTES - 1);
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          start_c    = 1'b1;
          next_state = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        last_idx_c = CNT_W'(LEN_BYTES - 1);
        if (accept_c) next_state = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        last_idx_c = CNT_W'(LEN_BYTES - 1);
        if (word_valid_c) begin
          len_load_c = 1'b1;
          next_state = (word_c[ADDR_W-1:0] != '0) ? ST_DATA : ST_CHECK;
        end
      end
      ST_DATA: begin
        if (word_valid_c) begin
          write_c = 1'b1;
          if ((idx_q + ADDR_W'(1)) == len_q) next_state = ST_CHECK;
        end
      end
      ST_CHECK: begin
        last_idx_c = CNT_W'(CSUM_BYTES - 1);
        if (word_valid_c) next_state = (word_c == acc_q) ? ST_DONE : ST_ERROR;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Status outputs are registered images of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      pm_we       <= 1'b0;
      pm_addr     <= '0;
      pm_wdata    <= '0;
      rx_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cpu_reset_n <= 1'b0;
    end else begin
      state_q     <= next_state;
      pm_we       <= write_c;
      rx_ready    <= is_busy(next_state);
      busy        <= is_busy(next_state);
      done        <= (next_state == ST_DONE);
      error       <= (next_state == ST_ERROR);
      cpu_reset_n <= (next_state == ST_DONE);
      if (len_load_c) len_q <= word_c[ADDR_W-1:0];
      if (start_c) begin
        idx_q <= '0;
        acc_q <= '0;
      end else if (write_c) begin
        idx_q <= idx_q + ADDR_W'(1);
        acc_q <= acc_q ^ word_c;
      end
      if (write_c) begin
        pm_addr  <= BASE_ADDR + idx_q;
        pm_wdata <= word_c;
      end
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench: two loaders (base 0000 and FFFF) share one stream and are
// checked against a queue-based model of the expected writes and final status.
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  logic        rx_ready0, pm_we0, cpu_reset_n0, busy0, done0, error0;
  logic [15:0] pm_addr0, words_loaded0;
  logic [31:0] pm_wdata0;
  logic        rx_ready1, pm_we1, cpu_reset_n1, busy1, done1, error1;
  logic [15:0] pm_addr1, words_loaded1;
  logic [31:0] pm_wdata1;

  int total = 0;
  int passed = 0;

  logic [31:0] load_words[$];
  logic [47:0] exp0[$];
  logic [47:0] exp1[$];
  logic [47:0] e0, e1;

  always #5 clk = ~clk;

  prog_mem_loader #(.BASE_ADDR(16'h0000)) dut0 (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready0), .pm_we(pm_we0), .pm_addr(pm_addr0), .pm_wdata(pm_wdata0),
    .cpu_reset_n(cpu_reset_n0), .busy(busy0), .done(done0), .error(error0),
    .words_loaded(words_loaded0)
  );

  prog_mem_loader #(.BASE_ADDR(16'hFFFF)) dut1 (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready1), .pm_we(pm_we1), .pm_addr(pm_addr1), .pm_wdata(pm_wdata1),
    .cpu_reset_n(cpu_reset_n1), .busy(busy1), .done(done1), .error(error1),
    .words_loaded(words_loaded1)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!reset) begin
      if (pm_we0) begin
        check("write_expected0", 32'(exp0.size() > 0), 32'd1);
        if (exp0.size() > 0) begin
          e0 = exp0.pop_front();
          check("pm_addr0", 32'(pm_addr0), 32'(e0[47:32]));
          check("pm_wdata0", pm_wdata0, e0[31:0]);
        end
      end
      if (pm_we1) begin
        check("write_expected1", 32'(exp1.size() > 0), 32'd1);
        if (exp1.size() > 0) begin
          e1 = exp1.pop_front();
          check("pm_addr1", 32'(pm_addr1), 32'(e1[47:32]));
          check("pm_wdata1", pm_wdata1, e1[31:0]);
        end
      end
    end
  end

  task automatic check_reset_values();
    check("rst_rx_ready0", 32'(rx_ready0), 32'd0);
    check("rst_pm_we0", 32'(pm_we0), 32'd0);
    check("rst_pm_addr0", 32'(pm_addr0), 32'd0);
    check("rst_pm_wdata0", pm_wdata0, 32'd0);
    check("rst_cpu_reset_n0", 32'(cpu_reset_n0), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_done0", 32'(done0), 32'd0);
    check("rst_error0", 32'(error0), 32'd0);
    check("rst_words_loaded0", 32'(words_loaded0), 32'd0);
    check("rst_pm_addr1", 32'(pm_addr1), 32'd0);
    check("rst_pm_wdata1", pm_wdata1, 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int t;
    repeat ($urandom_range(0, gap_max)) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready0 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t == 64) check("rx_ready_timeout", 32'(rx_ready0), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Start pulse with a junk byte offered on the same edge; it must not be taken.
  task automatic pulse_start();
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    check("start_rx_ready_low", 32'(rx_ready0), 32'd0);
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
    check("start_busy0", 32'(busy0), 32'd1);
    check("start_rx_ready0", 32'(rx_ready0), 32'd1);
    check("start_rx_ready1", 32'(rx_ready1), 32'd1);
    check("start_cpu_reset_n0", 32'(cpu_reset_n0), 32'd0);
    check("start_done0", 32'(done0), 32'd0);
    check("start_error0", 32'(error0), 32'd0);
    check("start_words_loaded0", 32'(words_loaded0), 32'd0);
  endtask

  task automatic run_load(input logic [31:0] trailer, input int gap_max);
    logic [31:0] x;
    logic [31:0] w;
    int n;
    bit ok;
    x = '0;
    n = load_words.size();
    for (int i = 0; i < n; i++) begin
      x ^= load_words[i];
      exp0.push_back({16'(16'h0000 + i), load_words[i]});
      exp1.push_back({16'(16'hFFFF + i), load_words[i]});
    end
    ok = (trailer == x);
    pulse_start();
    send_byte(8'(n >> 8), gap_max);
    send_byte(8'(n), gap_max);
    for (int i = 0; i < n; i++) begin
      w = load_words[i];
      for (int k = 3; k >= 0; k--) send_byte(8'(w >> (8 * k)), gap_max);
    end
    for (int k = 3; k >= 0; k--) send_byte(8'(trailer >> (8 * k)), gap_max);
    check("done0", 32'(done0), 32'(ok));
    check("error0", 32'(error0), 32'(!ok));
    check("cpu_reset_n0", 32'(cpu_reset_n0), 32'(ok));
    check("busy0", 32'(busy0), 32'd0);
    check("words_loaded0", 32'(words_loaded0), 32'(n));
    check("pending_writes0", 32'(exp0.size()), 32'd0);
    check("done1", 32'(done1), 32'(ok));
    check("error1", 32'(error1), 32'(!ok));
    check("words_loaded1", 32'(words_loaded1), 32'(n));
    check("pending_writes1", 32'(exp1.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] trailer;
    int n;
    #1 reset = 1'b1;
    #1 check_reset_values();
    @(negedge clk);
    reset = 1'b0;

    // Bytes offered while idle are refused.
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      check("idle_rx_ready0", 32'(rx_ready0), 32'd0);
      check("idle_busy0", 32'(busy0), 32'd0);
    end
    rx_valid = 1'b0;

    load_words = '{32'hDEADBEEF, 32'h12345678};
    run_load(32'hCC99E897, 0);

    run_load(32'h00000000, 0);
    run_load(32'hCC99E897, 0);

    load_words.delete();
    run_load(32'h00000000, 0);

    load_words = '{32'hDEADBEEF, 32'h12345678};
    run_load(32'hCC99E897, 3);

    // Asynchronous reset in the middle of word 0.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    #2 reset = 1'b1;
    #1 check_reset_values();
    exp0.delete();
    exp1.delete();
    @(negedge clk);
    reset = 1'b0;
    run_load(32'hCC99E897, 0);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 6);
      load_words.delete();
      x = '0;
      for (int i = 0; i < n; i++) begin
        load_words.push_back($urandom);
        x ^= load_words[i];
      end
      trailer = ($urandom_range(0, 1) == 1) ? (x ^ (32'd1 << $urandom_range(0, 31))) : x;
      run_load(trailer, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
